rc_unstuff_crc: RTL and testbench

- Receive-path stage directly downstream of decode_nrzi. Consumes its decoded serial stream and start_unstuff/end_unstuff framing.
- Removes USB stuffed bits and assembles LSB-first bytes for the SIPO/packet layer.
- Checks PID-relative packet length and CRC5 (token) or CRC16 (data).
- Reports per-packet status to the receive FSM.

---
 rtl/rc_unstuff_crc.sv | 141 ++++++++++++++
 tb/tb_rc_unstuff_crc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc_unstuff_crc.sv
// rc_unstuff_crc: USB receive bit unstuffer, LSB-first byte assembler and PID-relative length/CRC checker
module rc_unstuff_crc #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_in,
  input  logic       start_unstuff,
  input  logic       end_unstuff,
  input  logic [1:0] pkt_type,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic       stuff_error,
  output logic       crc_error,
  output logic       len_error
);
  localparam int OW = $clog2(STUFF_LEN + 1);
  typedef enum logic [2:0] {IDLE, PID, BODY, ERR, DONE} state_t;
  state_t        state_q, state_d;
  logic [OW-1:0] ones_q, ones_d, ones_b;
  logic [15:0]   cnt_q, cnt_d, cnt_b;
  logic [6:0]    sh_q, sh_d;
  logic [4:0]    crc5_q, crc5_d, crc5_b;
  logic [15:0]   crc16_q, crc16_d, crc16_b;
  logic [1:0]    type_q, type_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          stuff_error_q, stuff_error_d;
  logic          crc_error_q, crc_error_d;
  logic          len_error_q, len_error_d;
  logic          proc, body, fb5, fb16, len_ok, res_ok;
  // Length and residual rules are judged on the state accumulated before the EOP cycle
  assign len_ok = type_q == 2'b01 ? cnt_q == 16'd24 :
                  type_q == 2'b10 ? (cnt_q >= 16'd24 && cnt_q[2:0] == 3'd0) : cnt_q == 16'd8;
  assign res_ok = type_q == 2'b01 ? crc5_q == 5'b01100 :
                  type_q == 2'b10 ? crc16_q == 16'h800D : 1'b1;
  // A start pulse restarts from a clean context and still consumes this cycle's bit
  assign proc = start_unstuff || ((state_q == PID || state_q == BODY) && !end_unstuff);
  assign body = !start_unstuff && state_q == BODY;
  // Next-state, unstuffing, byte assembly, CRC update and end-of-packet checks
  always_comb begin
    ones_b        = start_unstuff ? '0 : ones_q;
    cnt_b         = start_unstuff ? '0 : cnt_q;
    crc5_b        = start_unstuff ? 5'h1F : crc5_q;
    crc16_b       = start_unstuff ? 16'hFFFF : crc16_q;
    fb5           = crc5_b[4] ^ s_in;
    fb16          = crc16_b[15] ^ s_in;
    state_d       = state_q;
    ones_d        = ones_b;
    cnt_d         = cnt_b;
    sh_d          = sh_q;
    crc5_d        = crc5_b;
    crc16_d       = crc16_b;
    type_d        = type_q;
    byte_out_d    = byte_out_q;
    byte_valid_d  = 1'b0;
    pkt_ok_d      = pkt_ok_q;
    stuff_error_d = stuff_error_q;
    crc_error_d   = crc_error_q;
    len_error_d   = len_error_q;
    if (start_unstuff) begin
      state_d       = PID;
      type_d        = pkt_type;
      pkt_ok_d      = 1'b0;
      stuff_error_d = 1'b0;
      crc_error_d   = 1'b0;
      len_error_d   = 1'b0;
    end else if (end_unstuff && (state_q == PID || state_q == BODY || state_q == ERR)) begin
      state_d     = DONE;
      len_error_d = state_q != ERR && !len_ok;
      crc_error_d = state_q != ERR && len_ok && !res_ok;
      pkt_ok_d    = state_q != ERR && len_ok && res_ok;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
    if (proc) begin
      if (ones_b == OW'(STUFF_LEN)) begin
        ones_d = '0;
        if (s_in) begin
          stuff_error_d = 1'b1;
          state_d       = ERR;
        end
      end else begin
        ones_d = s_in ? ones_b + 1'b1 : '0;
        sh_d   = {s_in, sh_q[6:1]};
        cnt_d  = &cnt_b ? cnt_b : cnt_b + 16'd1;
        if (cnt_b[2:0] == 3'd7) begin
          byte_valid_d = 1'b1;
          byte_out_d   = {s_in, sh_q};
        end
        if (cnt_b == 16'd7) state_d = BODY;
        if (body) begin
          crc5_d  = {crc5_b[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
          crc16_d = {crc16_b[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
        end
      end
    end
  end
  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ones_q        <= '0;
      cnt_q         <= '0;
      sh_q          <= '0;
      crc5_q        <= 5'h1F;
      crc16_q       <= 16'hFFFF;
      type_q        <= '0;
      byte_out_q    <= '0;
      byte_valid_q  <= 1'b0;
      pkt_ok_q      <= 1'b0;
      stuff_error_q <= 1'b0;
      crc_error_q   <= 1'b0;
      len_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ones_q        <= ones_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      crc5_q        <= crc5_d;
      crc16_q       <= crc16_d;
      type_q        <= type_d;
      byte_out_q    <= byte_out_d;
      byte_valid_q  <= byte_valid_d;
      pkt_ok_q      <= pkt_ok_d;
      stuff_error_q <= stuff_error_d;
      crc_error_q   <= crc_error_d;
      len_error_q   <= len_error_d;
    end
  end
  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign pkt_done    = state_q == DONE;
  assign pkt_ok      = pkt_ok_q;
  assign stuff_error = stuff_error_q;
  assign crc_error   = crc_error_q;
  assign len_error   = len_error_q;
endmodule

// File: tb/tb_rc_unstuff_crc.sv
// tb_rc_unstuff_crc: scoreboard bench with a packet-level reference model
module tb_rc_unstuff_crc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_in = 1'b0;
  logic       start_unstuff = 1'b0;
  logic       end_unstuff = 1'b0;
  logic [1:0] pkt_type = 2'b00;
  logic [7:0] byte_out;
  logic       byte_valid, pkt_done, pkt_ok, stuff_error, crc_error, len_error;
  typedef struct {
    int cyc;
    bit ok, se, ce, le, all;
  } exp_t;
  exp_t       exp_p[$];
  logic [7:0] exp_b[$];
  bit         pk[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       r;
  logic [7:0] b;
  rc_unstuff_crc #(.STUFF_LEN(6)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .start_unstuff(start_unstuff),
    .end_unstuff(end_unstuff), .pkt_type(pkt_type), .byte_out(byte_out),
    .byte_valid(byte_valid), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .stuff_error(stuff_error), .crc_error(crc_error), .len_error(len_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Monitor: pops the scoreboard whenever the DUT presents a byte or a packet status
  always @(negedge clk) begin
    if (!rst) begin
      if (byte_valid) begin
        if (exp_b.size() == 0) check("unexpected_byte", byte_out, -1);
        else begin
          b = exp_b.pop_front();
          check("byte_out", byte_out, b);
        end
      end
      if (pkt_done) begin
        if (exp_p.size() == 0) check("unexpected_pkt_done", 1, 0);
        else begin
          r = exp_p.pop_front();
          check("done_cycle", cyc, r.cyc);
          check("pkt_ok", pkt_ok, r.ok);
          check("stuff_error", stuff_error, r.se);
          if (r.all) begin
            check("crc_error", crc_error, r.ce);
            check("len_error", len_error, r.le);
          end
        end
      end
    end
  end
  task automatic push_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) pk.push_back(v[i]);
  endtask
  task automatic add_crc5();
    logic [4:0] c = 5'h1F;
    for (int i = 8; i < pk.size(); i++) c = {c[3:0], 1'b0} ^ ((c[4] ^ pk[i]) ? 5'h05 : 5'h00);
    for (int i = 4; i >= 0; i--) pk.push_back(~c[i]);
  endtask
  task automatic add_crc16();
    logic [15:0] c = 16'hFFFF;
    for (int i = 8; i < pk.size(); i++) c = {c[14:0], 1'b0} ^ ((c[15] ^ pk[i]) ? 16'h8005 : 16'h0000);
    for (int i = 15; i >= 0; i--) pk.push_back(~c[i]);
  endtask
  task automatic push_exp_bytes(input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) v[j] = pk[8*i+j];
      exp_b.push_back(v);
    end
  endtask
  task automatic drive_line(input logic [1:0] t, input bit raw);
    bit line[$];
    int run = 0;
    foreach (pk[i]) begin
      line.push_back(pk[i]);
      run = pk[i] ? run + 1 : 0;
      if (!raw && run == 6) begin
        line.push_back(1'b0);
        run = 0;
      end
    end
    foreach (line[i]) begin
      @(posedge clk); #1;
      start_unstuff = (i == 0);
      end_unstuff = 1'b0;
      pkt_type = t;
      s_in = line[i];
    end
  endtask
  task automatic end_pkt(input bit ok, input bit se, input bit ce, input bit le, input bit all);
    exp_t e;
    @(posedge clk); #1;
    start_unstuff = 1'b0;
    s_in = 1'b0;
    end_unstuff = 1'b1;
    e.cyc = cyc + 1;
    e.ok = ok;
    e.se = se;
    e.ce = ce;
    e.le = le;
    e.all = all;
    exp_p.push_back(e);
    @(posedge clk); #1;
    end_unstuff = 1'b0;
    repeat (2) @(posedge clk);
  endtask
  task automatic send_pkt(input logic [1:0] t, input bit crc_bad);
    int n = pk.size();
    bit lok, cerr;
    lok = (t == 2'b01) ? n == 24 : (t == 2'b10) ? (n >= 24 && n % 8 == 0) : n == 8;
    cerr = lok && crc_bad && (t == 2'b01 || t == 2'b10);
    push_exp_bytes(n / 8);
    drive_line(t, 1'b0);
    end_pkt(lok && !cerr, 1'b0, cerr, !lok, 1'b1);
  endtask
  task automatic send_ack();
    pk = {};
    push_bits(16'hD2, 8);
    send_pkt(2'b00, 1'b0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, mode, nb, k;
    repeat (3) @(posedge clk);
    #1;
    check("rst_byte_out", byte_out, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_flags", {pkt_ok, stuff_error, crc_error, len_error}, 0);
    rst = 1'b0;
    send_ack();
    pk = {};
    push_bits(16'h2D, 8); push_bits(16'h00, 8); push_bits(16'h10, 8);
    send_pkt(2'b01, 1'b0);
    pk = {};
    push_bits(16'h2D, 8); push_bits(16'h00, 8); push_bits(16'h10, 8);
    pk[10] = ~pk[10];
    send_pkt(2'b01, 1'b1);
    pk = {};
    push_bits(16'hC3, 8); push_bits(16'h00, 8); push_bits(16'h00, 8);
    send_pkt(2'b10, 1'b0);
    pk = {};
    push_bits(16'hC3, 8); push_bits(16'h00, 8);
    send_pkt(2'b10, 1'b0);
    pk = {};
    push_bits(16'hC3, 8); push_bits(16'hFF, 8); push_bits(16'hFF, 8);
    add_crc16();
    send_pkt(2'b10, 1'b0);
    pk = {};
    push_bits(16'hC3, 8); push_bits(16'h7F, 7);
    push_exp_bytes(1);
    drive_line(2'b10, 1'b1);
    end_pkt(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    send_ack();
    pk = {};
    push_bits(16'h2D, 8); push_bits(16'h5, 4);
    push_exp_bytes(1);
    drive_line(2'b01, 1'b0);
    @(posedge clk); #1;
    s_in = 1'b0;
    start_unstuff = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_byte_out", byte_out, 0);
    check("midrst_byte_valid", byte_valid, 0);
    check("midrst_pkt_done", pkt_done, 0);
    check("midrst_flags", {pkt_ok, stuff_error, crc_error, len_error}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_ack();
    pk = {};
    push_bits(16'hC3, 8); push_bits(16'h3, 2);
    push_exp_bytes(1);
    drive_line(2'b10, 1'b0);
    send_ack();
    for (int p = 0; p < 40; p++) begin
      t = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      pk = {};
      if (t == 1) begin
        push_bits($urandom_range(0, 1) ? 16'h2D : 16'hE1, 8);
        push_bits(16'($urandom), 11);
        add_crc5();
      end else if (t == 2) begin
        push_bits($urandom_range(0, 1) ? 16'hC3 : 16'h4B, 8);
        nb = $urandom_range(0, 4);
        for (int i = 0; i < nb; i++) push_bits($urandom_range(0, 1) ? 16'hFF : 16'($urandom_range(0, 255)), 8);
        add_crc16();
      end else begin
        push_bits(16'($urandom_range(0, 255)), 8);
      end
      if (mode == 1 && (t == 1 || t == 2)) begin
        k = $urandom_range(8, pk.size() - 1);
        pk[k] = ~pk[k];
        send_pkt(2'(t), 1'b1);
      end else if (mode == 2) begin
        repeat ($urandom_range(1, 7)) void'(pk.pop_back());
        send_pkt(2'(t), 1'b0);
      end else begin
        send_pkt(2'(t), 1'b0);
      end
    end
    repeat (5) @(posedge clk);
    #1;
    check("bytes_outstanding", exp_b.size(), 0);
    check("pkts_outstanding", exp_p.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
